l2_line_responder: RTL and testbench

//  L2-side responder for the L1 refill/write-back interface: the other end of the L1 cache's

---
 rtl/l2_line_responder.sv | 153 +++++++++++++++
 tb/tb_l2_line_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_responder.sv
// L2-side line responder for the L1 refill / write-back handshake.
// Holds a small line-addressed backing store. Each accepted request completes after a fixed
// latency with a one-cycle ready pulse, followed by one idle gap cycle.
module l2_line_responder #(
  parameter int unsigned LINE_W     = 512,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned OFFSET_W   = 6,
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_L1_L2,
  input  logic              read_L1_L2,
  input  logic              write_L1_L2,
  input  logic [LINE_W-1:0] write_data_L1_L2,
  output logic              ready_L2_L1,
  output logic [LINE_W-1:0] read_data_L2_L1,
  output logic              busy
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam int unsigned IdxLo   = OFFSET_W;
  localparam int unsigned IdxHi   = OFFSET_W + DEPTH_LOG2 - 1;
  localparam logic [3:0]  LatLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StGap
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_next;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic                    r_is_write;
  logic [LINE_W-1:0]       r_wdata;
  logic [Depth-1:0]        r_valid;
  logic [LINE_W-1:0]       r_mem [Depth];
  logic [LINE_W-1:0]       r_rdata;

  logic                    w_req;
  logic                    w_accept;
  logic                    w_enter_resp;
  logic                    w_commit;
  logic [DEPTH_LOG2-1:0]   w_idx_in;
  logic [DEPTH_LOG2-1:0]   w_resp_idx;
  logic                    w_resp_is_write;
  logic                    w_unused_addr;

  assign w_req    = read_L1_L2 | write_L1_L2;
  assign w_idx_in = address_L1_L2[IdxHi:IdxLo];

  // Tag bits above the index and the byte offset never take part in addressing.
  assign w_unused_addr = ^{address_L1_L2[ADDR_W-1:IdxHi+1], address_L1_L2[IdxLo-1:0]};

  // With LATENCY=1 the response starts straight from IDLE, before the request is latched,
  // so the index and op are taken from the live inputs in that case.
  assign w_resp_idx      = (r_state == StIdle) ? w_idx_in : r_idx;
  assign w_resp_is_write = (r_state == StIdle) ? write_L1_L2 : r_is_write;

  assign w_commit = (r_state == StResp) && r_is_write;

  // Next-state, counter and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_accept   = 1'b1;
          w_cnt_next = LatLoad;
          if (LATENCY == 1) begin
            w_state_next = StResp;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) begin
          w_state_next = StResp;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      StResp:  w_state_next = StGap;
      StGap:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State and latency counter; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request capture on acceptance; write data is held for the commit in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_idx      <= w_idx_in;
      r_is_write <= write_L1_L2;
      r_wdata    <= write_data_L1_L2;
    end
  end

  // Read data is loaded on the edge into RESP so it lines up with the ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_enter_resp && !w_resp_is_write) begin
      r_rdata <= r_valid[w_resp_idx] ? r_mem[w_resp_idx] : '0;
    end
  end

  // Line-valid bits: cleared by reset, set when a write-back commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_commit) begin
      r_valid[r_idx] <= 1'b1;
    end
  end

  // Line storage is deliberately not reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_commit && !rst) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign ready_L2_L1     = (r_state == StResp);
  assign busy            = (r_state != StIdle);
  assign read_data_L2_L1 = r_rdata;

endmodule

// File: tb/tb_l2_line_responder.sv
// Self-checking bench for l2_line_responder: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_l2_line_responder;

  localparam int LW  = 512;
  localparam int AW  = 64;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          rd, wr;
  logic [LW-1:0] wdata;
  logic          ready;
  logic [LW-1:0] rdata;
  logic          busy;

  logic [AW-1:0] addr1;
  logic          rd1, wr1;
  logic [LW-1:0] wdata1;
  logic          ready1;
  logic [LW-1:0] rdata1;
  logic          busy1;

  always #5 clk = ~clk;

  l2_line_responder #(.LATENCY(LAT)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .address_L1_L2    (addr),
    .read_L1_L2       (rd),
    .write_L1_L2      (wr),
    .write_data_L1_L2 (wdata),
    .ready_L2_L1      (ready),
    .read_data_L2_L1  (rdata),
    .busy             (busy)
  );

  l2_line_responder #(.LATENCY(1)) u_dut1 (
    .clk              (clk),
    .rst              (rst),
    .address_L1_L2    (addr1),
    .read_L1_L2       (rd1),
    .write_L1_L2      (wr1),
    .write_data_L1_L2 (wdata1),
    .ready_L2_L1      (ready1),
    .read_data_L2_L1  (rdata1),
    .busy             (busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: a line store plus the edge numbers at which the current
  // request responds and the next one may be accepted.
  logic [LW-1:0] m_mem [64];
  bit            m_valid [64];
  int            m_edge     = 0;
  int            m_next_acc = 0;
  int            m_resp_edge;
  bit            m_pend     = 0;
  bit            m_inresp   = 0;
  bit            m_wr;
  int            m_idx;
  logic [LW-1:0] m_wd;
  logic [LW-1:0] m_rdata = '0;
  bit            m_ready = 0;
  bit            m_busy  = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_edge = 0; m_next_acc = 0; m_pend = 0; m_inresp = 0;
        m_rdata = '0; m_ready = 0; m_busy = 0;
      end else begin
        m_edge++;
        if (m_inresp) begin
          if (m_wr) begin
            m_mem[m_idx]   = m_wd;
            m_valid[m_idx] = 1'b1;
          end
          m_inresp   = 0;
          m_pend     = 0;
          m_next_acc = m_edge + 2;
        end else if (m_pend && m_edge == m_resp_edge) begin
          m_inresp = 1;
          if (!m_wr) m_rdata = m_valid[m_idx] ? m_mem[m_idx] : '0;
        end else if (!m_pend && m_edge >= m_next_acc && (rd || wr)) begin
          m_pend      = 1;
          m_wr        = wr;
          m_idx       = int'(addr[11:6]);
          m_wd        = wdata;
          m_resp_edge = m_edge + LAT;
        end
        m_ready = m_inresp;
        m_busy  = m_pend || (m_edge < m_next_acc - 1);
      end
    end
  end

  // Compare process: every falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("ready", {511'b0, ready}, {511'b0, m_ready});
      chk("busy", {511'b0, busy}, {511'b0, m_busy});
      chk("read_data", rdata, m_rdata);
    end
  end

  // Drives one request, holds it until ready or a cycle bound, then drops it.
  // lat counts edges after the accept edge until ready is observed.
  task automatic xact(input bit w, input bit r, input logic [AW-1:0] a, input logic [LW-1:0] d,
                      output logic [LW-1:0] got, output int lat, output bit seen);
    @(negedge clk);
    #2;
    addr = a; wr = w; rd = r; wdata = d;
    lat  = 0;
    seen = 0;
    got  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1;
        got  = rdata;
        break;
      end
      lat++;
    end
    #2;
    rd = 0; wr = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL ready_timeout: got no ready within 40 cycles, required a pulse");
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  logic [LW-1:0] pat_a5, ones, got;
  int            lat;
  bit            seen;
  bit            saw_ready;
  int            last_hi, pulses;

  initial begin
    pat_a5 = {16{32'hA5A5_0001}};
    ones   = '1;
    rst = 1'b1; rd = 0; wr = 0; addr = '0; wdata = '0;
    rd1 = 0; wr1 = 0; addr1 = 64'h40; wdata1 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", {511'b0, ready}, '0);
    chk("rst_busy", {511'b0, busy}, '0);
    chk("rst_rdata", rdata, '0);
    #2 rst = 1'b0;
    xact(0, 1, 64'h1040, '0, got, lat, seen);
    chk("rd_after_rst", got, '0);

    // Write then read
    xact(1, 0, 64'h1040, pat_a5, got, lat, seen);
    chk("wr_latency", 512'(lat), 512'(4));
    xact(0, 1, 64'h1040, '0, got, lat, seen);
    chk("rd_latency", 512'(lat), 512'(4));
    chk("rd_data_a5", got, pat_a5);

    // Aliasing and offset: index 1 again
    xact(0, 1, 64'h1000_1078, '0, got, lat, seen);
    chk("alias_data", got, pat_a5);

    // Both requests high: write wins, read data held at the write's ready
    xact(1, 1, 64'h80, ones, got, lat, seen);
    chk("prio_rdata_held", got, pat_a5);
    xact(0, 1, 64'h80, '0, got, lat, seen);
    chk("prio_rd_ones", got, ones);

    // Reset in the second WAIT cycle aborts the write
    @(negedge clk);
    #2;
    addr = 64'h2000; wr = 1; wdata = rand_line();
    saw_ready = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready) saw_ready = 1;
    end
    #2 rst = 1'b1;
    @(negedge clk);
    if (ready) saw_ready = 1;
    #2;
    rst = 1'b0; wr = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready) saw_ready = 1;
    end
    chk("abort_no_ready", {511'b0, saw_ready}, '0);
    xact(0, 1, 64'h2000, '0, got, lat, seen);
    chk("abort_rd_zero", got, '0);

    // Randomized traffic over a few indices with random tags/offsets and occasional resets
    for (int t = 0; t < 200; t++) begin
      logic [AW-1:0] a;
      int            op;
      a       = {$urandom(), $urandom()};
      a[11:6] = 6'($urandom_range(0, 7));
      op      = int'($urandom_range(0, 9));
      if (op == 9) begin
        @(negedge clk);
        #2;
        addr = a; wr = $urandom_range(0, 1) == 1; rd = ~wr; wdata = rand_line();
        repeat ($urandom_range(0, 7)) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0; rd = 0; wr = 0;
        repeat (2) @(negedge clk);
      end else begin
        xact(op < 4, op >= 4 || op == 0, a, rand_line(), got, lat, seen);
        chk("rand_latency", 512'(lat), 512'(4));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    // LATENCY=1 instance: continuous read gives one-cycle pulses every 3 cycles
    @(negedge clk);
    #2 rd1 = 1;
    last_hi = -1;
    pulses  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready1) begin
        if (last_hi >= 0) chk("l1_period", 512'(i - last_hi), 512'(3));
        last_hi = i;
        pulses++;
      end
    end
    chk("l1_pulse_count_ok", {511'b0, pulses >= 13}, 512'(1));
    chk("l1_rdata_zero", rdata1, '0);
    #2 rd1 = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
